// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one adder64 between NUM_REQ requesters.
// Ports: clock/reset (async, active-high), req/a_in/b_in (per-requester, flattened),
//        sub_in (only with ADDER_ARB_SUB_EN), gnt/done (one-hot), result, owner, busy.
// Macro ADDER_ARB_SUB_EN adds per-request subtract via a second adder pass (EXEC2).
module adder64 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);
  logic [DATA_WIDTH-1:0] c;
  assign c[0] = 1'b0;
  genvar i;
  generate
    for (i = 0; i < DATA_WIDTH; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ c[i];
      if (i < DATA_WIDTH - 1) begin : g_c
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
    end
  endgenerate
endmodule

module adder_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_in,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]            sub_in,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
`ifdef ADDER_ARB_SUB_EN
    EXEC2,
`endif
    DONE
  } state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, sel;
  logic any;
  logic [DATA_WIDTH-1:0] op_a, op_b, add_a, add_b, sum;
`ifdef ADDER_ARB_SUB_EN
  logic op_sub;
  assign add_a = state == EXEC2 ? result : op_a;
  assign add_b = state == EXEC2 ? DATA_WIDTH'(1) : op_b;
`else
  assign add_a = op_a;
  assign add_b = op_b;
`endif
  assign busy = state != IDLE;
  adder64 #(.DATA_WIDTH(DATA_WIDTH)) u_add (.a(add_a), .b(add_b), .sum(sum));
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    return IW'(j >= NUM_REQ ? j - NUM_REQ : j);
  endfunction
  // Scan downward so the last hit, i.e. the closest at/after rr_ptr, wins.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[wrap(rr_ptr, k)]) begin
        any = 1'b1;
        sel = wrap(rr_ptr, k);
      end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      done   <= '0;
      result <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
`ifdef ADDER_ARB_SUB_EN
      op_sub <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt   <= NUM_REQ'(1) << sel;
          owner <= sel;
          op_a  <= a_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
`ifdef ADDER_ARB_SUB_EN
          op_sub <= sub_in[sel];
          op_b   <= sub_in[sel] ? ~b_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH]
                                :  b_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
`else
          op_b  <= b_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
`endif
          state <= EXEC;
        end
        EXEC: begin
          result <= sum;
`ifdef ADDER_ARB_SUB_EN
          // Subtract: A + ~B here, +1 in EXEC2.
          if (op_sub) state <= EXEC2;
          else begin
            done  <= gnt;
            state <= DONE;
          end
`else
          done  <= gnt;
          state <= DONE;
`endif
        end
`ifdef ADDER_ARB_SUB_EN
        EXEC2: begin
          result <= sum;
          done   <= gnt;
          state  <= DONE;
        end
`endif
        DONE: begin
          done   <= '0;
          gnt    <= '0;
          rr_ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
